// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, load, wrap/saturate and terminal-count outputs.
// Optional sticky overflow flag (ovf/ovf_clr) built when COUNTER_OVF_STICKY_EN is defined.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
`ifdef COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAXW = MAXV[WIDTH-1:0];

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   lv_ext;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] count_next;
    logic             event_edge;

    assign cnt_ext = {1'b0, count};
    assign lv_ext  = {1'b0, load_val};
    assign at_max  = (cnt_ext == MAXV);
    assign at_min  = (cnt_ext == '0);

    assign tc         = en & ((up_dn & at_max) | (~up_dn & at_min));
    assign event_edge = tc & ~clr & ~load;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = (lv_ext > MAXV) ? MAXW : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max)
                    count_next = count + WIDTH'(1);
                else if (SATURATE == 0)
                    count_next = '0;
            end else begin
                if (!at_min)
                    count_next = count - WIDTH'(1);
                else if (SATURATE == 0)
                    count_next = MAXW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= event_edge && (SATURATE == 0);
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    // A new overflow event beats a simultaneous clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (event_edge)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule
